// File: rtl/uart_tx.sv
// Frame transmitter: header, length and up to NMAX payload bytes sent as back-to-back
// 8N1-style characters, one serial bit per CLK cycle.
module uart_tx #(
  parameter int FULL_DATA_SIZE = 40,
  parameter int BYTE_SIZE      = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [FULL_DATA_SIZE-1:0] full_data,
  input  logic                      in_valid,
  output logic                      out_bit,
  output logic                      busy
);

  localparam int NMAX = FULL_DATA_SIZE / BYTE_SIZE - 2;
  // Counts characters still to send after the header: at most NMAX + 1.
  localparam int CW   = $clog2(NMAX + 2);
  localparam int BCW  = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                    state_q;
  logic                      out_bit_q;
  logic                      busy_q;
  logic [BCW-1:0]            bit_cnt_q;
  logic [CW-1:0]             left_q;
  logic [CW-1:0]             left_d;
  logic [BYTE_SIZE-1:0]      byte_q;
  logic [BYTE_SIZE-1:0]      len_w;
  logic [FULL_DATA_SIZE-1:0] hold_q;

  // Characters after the header: the length byte plus the clamped payload count.
  always_comb begin
    len_w = full_data[FULL_DATA_SIZE-1-BYTE_SIZE -: BYTE_SIZE];
    if (int'(len_w) > NMAX) left_d = CW'(NMAX + 1);
    else                    left_d = CW'(len_w) + CW'(1);
  end

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      out_bit_q <= 1'b1;
      busy_q    <= 1'b0;
      bit_cnt_q <= '0;
      left_q    <= '0;
      byte_q    <= '0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= START;
            out_bit_q <= 1'b0;
            busy_q    <= 1'b1;
            byte_q    <= full_data[FULL_DATA_SIZE-1 -: BYTE_SIZE];
            hold_q    <= full_data << BYTE_SIZE;
            left_q    <= left_d;
          end
        end
        START: begin
          state_q   <= DATA;
          out_bit_q <= byte_q[0];
          byte_q    <= byte_q >> 1;
          bit_cnt_q <= '0;
        end
        DATA: begin
          if (bit_cnt_q == BCW'(BYTE_SIZE - 1)) begin
            state_q   <= STOP;
            out_bit_q <= 1'b1;
          end else begin
            out_bit_q <= byte_q[0];
            byte_q    <= byte_q >> 1;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        STOP: begin
          // The next start bit follows the stop bit directly; no idle between characters.
          if (left_q != '0) begin
            state_q   <= START;
            out_bit_q <= 1'b0;
            byte_q    <= hold_q[FULL_DATA_SIZE-1 -: BYTE_SIZE];
            hold_q    <= hold_q << BYTE_SIZE;
            left_q    <= left_q - CW'(1);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_bit = out_bit_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random frames against a character-level
// model, and hand sequences for mid-frame requests, reset abort and back-to-back frames.
module tb_uart_tx;

  localparam int FDS    = 40;
  localparam int BS     = 8;
  localparam int NMAX   = FDS / BS - 2;
  localparam int BUDGET = 1000;

  logic           CLK = 1'b0;
  logic           RST;
  logic [FDS-1:0] full_data;
  logic           in_valid;
  logic           out_bit;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          got_q[$];
  bit          exp_q[$];
  bit          line_q[$];
  logic [7:0]  exp_chars[$];
  logic [7:0]  dec_chars[$];
  int          framing_errs;

  typedef struct {
    logic [FDS-1:0] data;
    int             cycles;
  } vec_t;

  uart_tx #(.FULL_DATA_SIZE(FDS), .BYTE_SIZE(BS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .full_data(full_data),
    .in_valid (in_valid),
    .out_bit  (out_bit),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: list of characters for a request, then the line bits of those characters.
  function automatic void build_expected(input logic [FDS-1:0] d);
    logic [7:0] c;
    int         len, le;
    exp_q.delete();
    exp_chars.delete();
    len = int'(d[FDS-1-BS -: BS]);
    le  = (len > NMAX) ? NMAX : len;
    for (int k = 0; k < 2 + le; k++) exp_chars.push_back(d[FDS-1-k*BS -: BS]);
    foreach (exp_chars[i]) begin
      c = exp_chars[i];
      exp_q.push_back(1'b0);
      for (int b = 0; b < BS; b++) exp_q.push_back(c[b]);
      exp_q.push_back(1'b1);
    end
  endfunction

  function automatic int first_diff();
    int m;
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] != exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return m;
    return -1;
  endfunction

  // 4x-oversampling receiver run over a recorded line: finds the falling edge,
  // samples mid-bit, flags a missing stop bit as a framing error.
  function automatic void decode_line();
    bit s[$];
    int i, mid;
    logic [7:0] c;
    dec_chars.delete();
    framing_errs = 0;
    foreach (line_q[j]) repeat (4) s.push_back(line_q[j]);
    i = 0;
    while (i < s.size()) begin
      if (s[i] == 1'b0) begin
        mid = i + 2;
        if (mid + 4*(BS+1) >= s.size()) begin
          framing_errs++;
          break;
        end
        for (int b = 0; b < BS; b++) c[b] = s[mid + 4*(b+1)];
        if (s[mid + 4*(BS+1)] != 1'b1) framing_errs++;
        dec_chars.push_back(c);
        i = mid + 4*(BS+1);
      end else begin
        i++;
      end
    end
  endfunction

  task automatic send(input logic [FDS-1:0] d, input bit hold);
    @(negedge CLK);
    full_data = d;
    in_valid  = 1'b1;
    @(negedge CLK);
    if (!hold) in_valid = 1'b0;
  endtask

  // Called at the negedge right after acceptance; records the line while busy.
  task automatic collect(input int poke_at, input logic [FDS-1:0] poke_data);
    int n;
    n = 0;
    got_q.delete();
    while (busy === 1'b1 && n < BUDGET) begin
      got_q.push_back(out_bit);
      if (poke_at >= 0 && n == poke_at) begin
        full_data = poke_data;
        in_valid  = 1'b1;
      end else if (poke_at >= 0 && n == poke_at + 1) begin
        in_valid = 1'b0;
      end
      n++;
      @(negedge CLK);
    end
    if (n >= BUDGET) check("frame_timeout", n, 0);
  endtask

  task automatic run_vector(input string tag, input logic [FDS-1:0] d, input int cycles);
    send(d, 1'b0);
    collect(-1, '0);
    build_expected(d);
    check({tag, "_cycles"}, got_q.size(), cycles);
    check({tag, "_bits"}, first_diff(), -1);
    check({tag, "_idle_line"}, out_bit, 1);
  endtask

  initial begin
    vec_t       vecs[6];
    logic [FDS-1:0] d;
    logic [19:0] prefix;
    int          busy_cnt;
    int          r;

    vecs[0] = '{40'h00_03_aa_bb_47, 50};
    vecs[1] = '{40'h00_01_aa_bb_47, 30};
    vecs[2] = '{40'h00_00_aa_bb_47, 20};
    vecs[3] = '{40'h5a_07_aa_bb_47, 50};
    vecs[4] = '{40'hc3_02_11_22_33, 40};
    vecs[5] = '{40'hff_ff_80_01_fe, 50};

    RST       = 1'b1;
    in_valid  = 1'b0;
    full_data = '0;
    @(posedge CLK);
    #1;
    check("reset_out_bit", out_bit, 1);
    check("reset_busy", busy, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Table vectors, with the literal line prefix of the first one.
    for (int v = 0; v < 6; v++) begin
      run_vector($sformatf("vec%0d", v), vecs[v].data, vecs[v].cycles);
      if (v == 0) begin
        prefix = '0;
        for (int i = 0; i < 20 && i < got_q.size(); i++) prefix[i] = got_q[i];
        check("vec0_prefix", prefix, 20'h81A00);
      end
    end

    // Random requests against the model; lengths mostly near the clamp boundary.
    for (int t = 0; t < 10; t++) begin
      d = {$urandom(), $urandom()};
      r = $urandom_range(0, 3);
      d[FDS-1-BS -: BS] = (r < 3) ? 8'($urandom_range(0, NMAX + 1)) : 8'($urandom_range(0, 255));
      build_expected(d);
      run_vector($sformatf("rand%0d", t), d, exp_q.size());
    end

    // Mid-frame request with new data is ignored and leaves the frame intact.
    d = 40'h3c_03_de_ad_be;
    send(d, 1'b0);
    collect(17, 40'h99_01_55_66_77);
    build_expected(d);
    check("ignore_bits", first_diff(), -1);
    busy_cnt = 0;
    repeat (60) begin
      @(negedge CLK);
      if (busy) busy_cnt++;
    end
    check("ignore_no_second_frame", busy_cnt, 0);

    // Reset during a payload character aborts at once; no resumption after release.
    send(40'h12_03_f0_0f_a5, 1'b0);
    repeat (24) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_out_bit", out_bit, 1);
    check("abort_busy", busy, 0);
    @(posedge CLK);
    #1;
    check("abort_busy_held", busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    busy_cnt = 0;
    repeat (5) begin
      @(negedge CLK);
      if (busy || !out_bit) busy_cnt++;
    end
    check("abort_no_resume", busy_cnt, 0);

    // Acceptance on the first edge after reset release.
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    d         = 40'h81_02_c0_ff_ee;
    RST       = 1'b0;
    full_data = d;
    in_valid  = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    check("first_accept_busy", busy, 1);
    check("first_accept_start", out_bit, 0);
    collect(-1, '0);
    build_expected(d);
    check("post_reset_bits", first_diff(), -1);

    // in_valid held high: repeated frames with exactly one idle cycle between them.
    d = 40'h7e_05_a1_b2_c3;
    build_expected(d);
    send(d, 1'b1);
    collect(-1, '0);
    line_q = got_q;
    check("held_f1_bits", first_diff(), -1);
    check("held_gap_line", out_bit, 1);
    check("held_gap_busy", busy, 0);
    line_q.push_back(out_bit);
    @(negedge CLK);
    check("held_restart_busy", busy, 1);
    in_valid = 1'b0;
    collect(-1, '0);
    check("held_f2_bits", first_diff(), -1);
    foreach (got_q[i]) line_q.push_back(got_q[i]);
    repeat (3) line_q.push_back(1'b1);
    decode_line();
    check("held_framing_errs", framing_errs, 0);
    check("held_char_count", dec_chars.size(), 2 * exp_chars.size());
    r = 0;
    foreach (dec_chars[i])
      if (i < 2 * exp_chars.size() && dec_chars[i] != exp_chars[i % exp_chars.size()]) r++;
    check("held_char_values", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter FULL_DATA_SIZE, default 40: width of the request word in bits, an integer multiple of BYTE_SIZE, at least 2*BYTE_SIZE.
REQ-002 Parameter BYTE_SIZE, default 8: data bits per UART character.
REQ-003 CLK  input  1: single clock, one serial bit period per CLK cycle (bit-rate clock).
REQ-004 RST  input  1: reset, asynchronous and active-high.
REQ-005 full_data  input  FULL_DATA_SIZE: request word; byte k occupies bits [FULL_DATA_SIZE-1-k*BYTE_SIZE -: BYTE_SIZE], k=0 most significant.
REQ-006 in_valid  input  1: request strobe, sampled on rising CLK.
REQ-007 out_bit  output  1: serial line, idle high.
REQ-008 busy  output  1: high while a frame is in progress.

Function
REQ-009 Request word layout: byte 0 = header H, byte 1 = payload length L, bytes 2..NMAX+1 = payload, NMAX = FULL_DATA_SIZE/BYTE_SIZE - 2 (3 at defaults).
REQ-010 Effective length LE = min(L, NMAX); L values above NMAX are clamped to NMAX.
REQ-011 Frame = H, then L (the unclamped value as received), then payload bytes 2..LE+1 in ascending k order; character count 2+LE.
REQ-012 Each character: start bit 0, BYTE_SIZE data bits LSB first, one stop bit 1; 10 cycles per character at defaults.
REQ-013 Consecutive characters are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
REQ-014 Total frame length is (2+LE)*(BYTE_SIZE+2) cycles, measured from the first start bit through the last stop bit.
REQ-015 A request is accepted on a rising CLK edge where in_valid=1 and busy=0; full_data is captured into an internal shift/hold register on that same edge.
REQ-016 out_bit and busy are registered: the start bit of H appears and busy=1 in the cycle immediately after the acceptance edge (latency 1).
REQ-017 in_valid while busy=1 is ignored: no queueing, and the captured data is unaffected by later changes of full_data.
REQ-018 In the cycle after the last stop bit, busy=0 and out_bit=1; a new request may be accepted on that edge, which gives a single idle cycle between frames.
REQ-019 Holding in_valid high continuously yields repeated frames, each separated by that one idle cycle.
REQ-020 State machine states: IDLE, START, DATA, STOP.
REQ-021 Transitions: IDLE->START on acceptance; START->DATA after 1 cycle; DATA->STOP after BYTE_SIZE cycles; STOP->START if characters remain, else STOP->IDLE.
REQ-022 The character counter and bit counter are sized from the parameters; no wrap-around occurs for any L in the range 0..2^BYTE_SIZE-1.
REQ-023 The header byte is transmitted verbatim, with no interpretation.

Reset
REQ-024 While RST=1, asynchronously: out_bit=1, busy=0, state=IDLE, counters=0.
REQ-025 Reset asserted mid-frame aborts the frame immediately; the line goes high and no partial character is resumed after release.
REQ-026 The first acceptance is possible on the first rising CLK edge after RST deasserts.

Verification
REQ-027 full_data=40'h00_03_aa_bb_47, 1-cycle in_valid -> 50-bit frame carrying characters 00,03,AA,BB,47; line bits start 0,00000000,1,0,11000000,1,...; busy high for 50 cycles.
REQ-028 40'h00_01_aa_bb_47 -> 30 cycles carrying 00,01,AA; 40'h00_00_aa_bb_47 -> 20 cycles carrying 00,00 only.
REQ-029 L=0x07 (clamped) -> characters H,07,AA,BB,47 over 50 cycles.
REQ-030 A second in_valid pulse with new full_data arriving mid-frame -> ignored; the current frame completes unchanged and no second frame is sent.
REQ-031 RST pulsed during a payload character -> out_bit=1 and busy=0 immediately; a new request after release produces a clean full frame.
REQ-032 in_valid held high -> identical frames repeated with exactly one idle-high cycle between them; decoding the line with a 4x-oversampling receiver recovers all characters with no framing errors.
